// File: rtl/htpa_bbox_find.sv
// rtl/htpa_bbox_find.sv - bounding box of hot pixels over one raster-scanned frame
module htpa_bbox_find #(
    parameter int COLS = 80,
    parameter int ROWS = 64,
    parameter int PW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sof,
    input  logic          pix_valid,
    input  logic [PW-1:0] pix_data,
    input  logic [PW-1:0] threshold,
    output logic [6:0]    xo,
    output logic [6:0]    xn,
    output logic [5:0]    yo,
    output logic [5:0]    yn,
    output logic          box_found,
    output logic          box_valid,
    output logic          frame_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic [6:0] X_LAST = 7'(COLS - 1);
    localparam logic [5:0] Y_LAST = 6'(ROWS - 1);

    logic [0:0] state;
    logic [6:0] x, xmin, xmax;
    logic [5:0] y, ymin, ymax;
    logic       any;

    logic       in_scan, at_last, start, accept, abort, hot, is_last;
    logic [6:0] cx, n_xmin, n_xmax;
    logic [5:0] cy, n_ymin, n_ymax;
    logic       n_any;

    // Decode the current pixel: a sof restarts the frame at (0,0) unless it
    // lands on the last pixel of a frame in progress, which then completes.
    always_comb begin
        in_scan = (state == ST_SCAN);
        at_last = (x == X_LAST) && (y == Y_LAST);
        start   = pix_valid && sof && !(in_scan && at_last);
        accept  = pix_valid && (in_scan || sof);
        abort   = start && in_scan;
        cx      = start ? 7'd0 : x;
        cy      = start ? 6'd0 : y;
        is_last = (cx == X_LAST) && (cy == Y_LAST);
        hot     = pix_data > threshold;
    end

    // Next running min/max including the current pixel.
    always_comb begin
        n_xmin = xmin;
        n_xmax = xmax;
        n_ymin = ymin;
        n_ymax = ymax;
        n_any  = any;
        if (start) begin
            n_xmin = 7'd0;
            n_xmax = 7'd0;
            n_ymin = 6'd0;
            n_ymax = 6'd0;
            n_any  = hot;
        end else if (hot) begin
            if (!any) begin
                n_xmin = cx;
                n_xmax = cx;
                n_ymin = cy;
                n_ymax = cy;
            end else begin
                if (cx < xmin) n_xmin = cx;
                if (cx > xmax) n_xmax = cx;
                if (cy < ymin) n_ymin = cy;
                if (cy > ymax) n_ymax = cy;
            end
            n_any = 1'b1;
        end
    end

    // Scan state, raster counters, running box and the published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            x         <= 7'd0;
            y         <= 6'd0;
            xmin      <= 7'd0;
            xmax      <= 7'd0;
            ymin      <= 6'd0;
            ymax      <= 6'd0;
            any       <= 1'b0;
            xo        <= 7'd0;
            xn        <= 7'd0;
            yo        <= 6'd0;
            yn        <= 6'd0;
            box_found <= 1'b0;
            box_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            box_valid <= 1'b0;
            frame_err <= abort;
            if (accept) begin
                xmin <= n_xmin;
                xmax <= n_xmax;
                ymin <= n_ymin;
                ymax <= n_ymax;
                any  <= n_any;
                if (is_last) begin
                    state     <= ST_IDLE;
                    x         <= 7'd0;
                    y         <= 6'd0;
                    box_valid <= 1'b1;
                    box_found <= n_any;
                    xo        <= n_any ? n_xmin : 7'd0;
                    xn        <= n_any ? n_xmax : 7'd0;
                    yo        <= n_any ? n_ymin : 6'd0;
                    yn        <= n_any ? n_ymax : 6'd0;
                end else begin
                    state <= ST_SCAN;
                    if (cx == X_LAST) begin
                        x <= 7'd0;
                        y <= cy + 6'd1;
                    end else begin
                        x <= cx + 7'd1;
                        y <= cy;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_htpa_bbox_find.sv
// tb/tb_htpa_bbox_find.sv - directed self-checking bench for htpa_bbox_find
module tb_htpa_bbox_find;

    localparam int COLS = 80;
    localparam int ROWS = 64;
    localparam int PW   = 16;
    localparam int NPIX = COLS * ROWS;

    logic          clk = 1'b0;
    logic          rst;
    logic          sof;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic [PW-1:0] threshold;
    logic [6:0]    xo, xn;
    logic [5:0]    yo, yn;
    logic          box_found, box_valid, frame_err;

    int checks = 0;
    int errors = 0;
    int bv_count = 0;
    int err_count = 0;

    int hx[2];
    int hy[2];
    int nhot;
    int bg;
    bit last_sof;

    htpa_bbox_find #(.COLS(COLS), .ROWS(ROWS), .PW(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sof       (sof),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .threshold (threshold),
        .xo        (xo),
        .xn        (xn),
        .yo        (yo),
        .yn        (yn),
        .box_found (box_found),
        .box_valid (box_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Count result and abort pulses away from the active edge.
    always @(negedge clk) begin
        if (box_valid) bv_count++;
        if (frame_err) err_count++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_hot(input int x, input int y);
        for (int k = 0; k < nhot; k++)
            if (hx[k] == x && hy[k] == y) return 1'b1;
        return 1'b0;
    endfunction

    // Sends the first npix pixels of a frame, starting with sof; called at a negedge.
    task automatic send_frame(input int npix, input bit gaps, input bit expect_err);
        for (int i = 0; i < npix; i++) begin
            pix_valid = 1'b1;
            sof       = (i == 0) || (last_sof && i == NPIX - 1);
            pix_data  = is_hot(i % COLS, i / COLS) ? 16'd200 : 16'(bg);
            @(negedge clk);
            pix_valid = 1'b0;
            sof       = 1'b0;
            pix_data  = 16'd0;
            if (i == 0) check("frame_err_on_sof", frame_err, expect_err);
            if (i == NPIX - 1) check("box_valid_latency", box_valid, 1);
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic check_box(input string tag, input int exo, input int exn,
                             input int eyo, input int eyn, input int ef);
        check({tag, "_xo"}, xo, exo);
        check({tag, "_xn"}, xn, exn);
        check({tag, "_yo"}, yo, eyo);
        check({tag, "_yn"}, yn, eyn);
        check({tag, "_found"}, box_found, ef);
    endtask

    initial begin
        rst = 1'b1; sof = 1'b1; pix_valid = 1'b1; pix_data = 16'd500;
        threshold = 16'd100; bg = 50; nhot = 0; last_sof = 1'b0;
        repeat (3) @(negedge clk);
        check_box("reset", 0, 0, 0, 0, 0);
        check("reset_box_valid", box_valid, 0);
        check("reset_frame_err", frame_err, 0);
        rst = 1'b0; sof = 1'b0; pix_valid = 1'b0;

        // Pixels with no preceding sof are ignored.
        pix_valid = 1'b1; pix_data = 16'd200;
        repeat (10) @(negedge clk);
        pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("no_sof_bv", bv_count, 0);

        // Single hot pixel at (5,7), continuous valid.
        nhot = 1; hx[0] = 5; hy[0] = 7;
        send_frame(NPIX, 1'b0, 1'b0);
        check_box("single", 5, 5, 7, 7, 1);
        repeat (5) @(negedge clk);
        check("hold_xo", xo, 5);
        check("single_bv", bv_count, 1);

        // Opposite corners with random valid gaps.
        nhot = 2; hx[0] = 79; hy[0] = 0; hx[1] = 0; hy[1] = 63;
        send_frame(NPIX, 1'b1, 1'b0);
        check_box("corners", 0, 79, 0, 63, 1);
        repeat (2) @(negedge clk);
        check("corners_bv", bv_count, 2);

        // All pixels equal to threshold; sof also flagged on the last pixel.
        nhot = 0; bg = 100; last_sof = 1'b1;
        send_frame(NPIX, 1'b0, 1'b0);
        check_box("none", 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("none_bv", bv_count, 3);
        check("none_err", err_count, 0);
        last_sof = 1'b0; bg = 50;

        // Frame aborted by sof at (10,3); following frame reports only its own pixel.
        nhot = 1; hx[0] = 2; hy[0] = 1;
        send_frame(3 * COLS + 10, 1'b0, 1'b0);
        hx[0] = 50; hy[0] = 40;
        send_frame(NPIX, 1'b0, 1'b1);
        check_box("abort", 50, 50, 40, 40, 1);
        repeat (2) @(negedge clk);
        check("abort_err", err_count, 1);
        check("abort_bv", bv_count, 4);

        // Reset mid-frame after a hot pixel at (2,2).
        hx[0] = 2; hy[0] = 2;
        send_frame(200, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_box("midrst", 0, 0, 0, 0, 0);
        check("midrst_bv", bv_count, 4);
        check("midrst_err", err_count, 1);
        hx[0] = 40; hy[0] = 30;
        send_frame(NPIX, 1'b0, 1'b0);
        check_box("clean", 40, 40, 30, 30, 1);
        repeat (2) @(negedge clk);
        check("clean_bv", bv_count, 5);
        check("clean_err", err_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
